// File: rtl/fb_scanout_reader.sv
// Purpose : read side of the monochrome framebuffer; fetches 16-bit words and serialises them MSB-first into a pixel stream.
// Latency : frame_start sampled on edge 0 -> first pixel_valid after edge 3; then 1 pixel/cycle with no word-boundary bubbles.
// Backpr. : pixel_ready low freezes pixel/pixel_valid; one prefetched word is held and no new read is issued while it is full.
//
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   frame_start        : one-cycle request to scan a full frame from address 0 (ignored while busy)
//   read_address, q    : framebuffer registered read port (q valid one clock after the RAM samples read_address)
//   pixel, pixel_valid, pixel_ready : serial pixel stream, valid/ready handshake (1 = white)
//   busy, frame_done   : frame in progress; one-cycle pulse after the last pixel is accepted
module fb_scanout_reader #(
    parameter int ADDR_WIDTH  = 13,
    parameter int WORD_WIDTH  = 16,
    parameter int FRAME_WORDS = 8192
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [WORD_WIDTH-1:0] q,
    output logic                  pixel,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(WORD_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Read pipeline: pend_issue = address loaded this cycle, pend_ram = RAM has
    // sampled it and q is valid at the next edge.
    logic                  pend_issue;
    logic                  pend_ram;
    logic                  pf_vld;
    logic [WORD_WIDTH-1:0] pf_dat;
    logic [WORD_WIDTH-1:0] shift_dat;
    logic [CNT_W-1:0]      shift_cnt;   // bits still to be presented from shift_dat

    logic start, issue, accept, last_take, load, finish;

    assign start     = (state == IDLE) && frame_start;
    assign accept    = pixel_valid && pixel_ready;
    assign last_take = accept && (shift_cnt == CNT_W'(1));
    // Refill on the same edge the last bit leaves, so words run back-to-back.
    assign load      = pf_vld && ((shift_cnt == '0) || last_take);
    // Address doubles as the issued-word counter: once it reaches LAST_ADDR
    // every word of the frame has been requested.
    assign issue     = (state == RUN) && !pf_vld && !pend_issue && !pend_ram
                       && (read_address != LAST_ADDR);
    assign finish    = (state == RUN) && (read_address == LAST_ADDR)
                       && !pend_issue && !pend_ram && !pf_vld && last_take;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = RUN;
            RUN:     if (finish)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy        = (state == RUN);
        pixel       = shift_dat[WORD_WIDTH-1];
        pixel_valid = (shift_cnt != '0);
    end

    // Datapath: address, read pipeline, prefetch slot and shifter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_address <= '0;
            pend_issue   <= 1'b0;
            pend_ram     <= 1'b0;
            pf_vld       <= 1'b0;
            pf_dat       <= '0;
            shift_dat    <= '0;
            shift_cnt    <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= finish;
            pend_issue <= start || issue;
            pend_ram   <= pend_issue;

            if (start) begin
                read_address <= '0;
            end else if (issue) begin
                read_address <= read_address + ADDR_WIDTH'(1);
            end

            if (load) begin
                shift_dat <= pf_dat;
                shift_cnt <= FULL_CNT;
            end else if (accept) begin
                shift_dat <= {shift_dat[WORD_WIDTH-2:0], 1'b0};
                shift_cnt <= shift_cnt - CNT_W'(1);
            end

            // A capture cannot coincide with a load: a read is only issued
            // while the prefetch slot is empty, so pend_ram implies !pf_vld.
            if (pend_ram) begin
                pf_dat <= q;
                pf_vld <= 1'b1;
            end else if (load) begin
                pf_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader with a reduced frame (512 words) and a registered RAM model.
module tb_fb_scanout_reader;

    localparam int AW     = 13;
    localparam int WW     = 16;
    localparam int FW     = 512;
    localparam int NPIX   = FW * WW;
    localparam int BUDGET = 40000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frame_start;
    logic [AW-1:0] read_address;
    logic [WW-1:0] q;
    logic          pixel;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    logic [WW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) q <= mem[read_address];

    fb_scanout_reader #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .FRAME_WORDS(FW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .read_address(read_address),
        .q           (q),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    int cyc_n, pix_idx, pix_err, stall_err, addr_err, done_cnt, done_cyc;
    int last_acc_cyc, first_valid_cyc, last_change_cyc, max_addr, start_at_pix;
    int rst_bad, stale_bad;
    bit ready_rand;
    logic [31:0]   head_bits;
    logic [AW-1:0] prev_addr;

    // Reference: pixel p is bit (15 - p%16) of word p/16.
    function automatic logic exp_pix(input int p);
        logic [WW-1:0] w;
        w = mem[p / WW];
        return w[WW-1-(p % WW)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc_n = 0; pix_idx = 0; pix_err = 0; stall_err = 0; addr_err = 0;
        done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; first_valid_cyc = -1;
        last_change_cyc = -100; max_addr = 0; start_at_pix = -1;
        head_bits = '0; prev_addr = read_address;
    endtask

    // One clock: inputs set at negedge, DUT edge, outputs observed at next negedge.
    task automatic cyc();
        logic acc, stalled, held, mid;
        pixel_ready = ready_rand ? ($urandom_range(0, 99) < 40) : 1'b1;
        mid = (start_at_pix >= 0) && (pix_idx == start_at_pix);
        if (mid) begin
            frame_start  = 1'b1;
            start_at_pix = -1;
        end
        acc     = reset_n && pixel_valid && pixel_ready;
        stalled = reset_n && pixel_valid && !pixel_ready;
        held    = pixel;
        if (acc) begin
            if (pixel !== exp_pix(pix_idx)) pix_err++;
            if (pix_idx < 32) head_bits[31-pix_idx] = pixel;
            pix_idx++;
            last_acc_cyc = cyc_n + 1;
        end
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        if (mid) frame_start = 1'b0;
        if (stalled && (pixel_valid !== 1'b1 || pixel !== held)) stall_err++;
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (pixel_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc_n;
        if (read_address !== prev_addr) begin
            if (read_address != '0) begin
                if (read_address != prev_addr + 1'b1) addr_err++;
                // a new read before the previous one's data has returned
                if (cyc_n - last_change_cyc < 3) addr_err++;
            end
            last_change_cyc = cyc_n;
            prev_addr = read_address;
            if (int'(read_address) > max_addr) max_addr = int'(read_address);
        end
    endtask

    task automatic start_frame();
        clear_stats();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic run_to_done();
        for (int i = 0; i < BUDGET && done_cnt == 0; i++) cyc();
    endtask

    task automatic check_frame(input string tag, input bit gapless);
        chk({tag, "_latency"},   first_valid_cyc - 1, 3);
        chk({tag, "_pixels"},    pix_idx, NPIX);
        chk({tag, "_pix_err"},   pix_err, 0);
        chk({tag, "_done_cnt"},  done_cnt, 1);
        chk({tag, "_done_time"}, done_cyc, last_acc_cyc);
        chk({tag, "_busy_end"},  busy, 1'b0);
        chk({tag, "_addr_hold"}, read_address, FW - 1);
        chk({tag, "_max_addr"},  max_addr, FW - 1);
        chk({tag, "_addr_err"},  addr_err, 0);
        chk({tag, "_stall_err"}, stall_err, 0);
        if (gapless) chk({tag, "_gapless"}, last_acc_cyc - first_valid_cyc, NPIX);
    endtask

    initial begin
        for (int k = 0; k < (1 << AW); k++)
            mem[k] = (k < FW) ? (WW'(k) ^ 16'hA5C3) : WW'($urandom);
        reset_n     = 1'b0;
        frame_start = 1'b1;
        pixel_ready = 1'b1;
        ready_rand  = 1'b0;
        clear_stats();

        // Reset held with frame_start and pixel_ready asserted
        rst_bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (read_address !== '0 || pixel_valid !== 1'b0 || busy !== 1'b0 ||
                frame_done !== 1'b0 || pixel !== 1'b0) rst_bad++;
        end
        chk("reset_outputs", rst_bad, 0);
        chk("reset_addr", read_address, 0);
        reset_n     = 1'b1;
        frame_start = 1'b0;
        cyc();
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", pixel_valid, 1'b0);

        // A: full frame, consumer always ready
        start_frame();
        run_to_done();
        for (int i = 0; i < 3; i++) cyc();
        check_frame("A", 1'b1);

        // B: word boundary pattern
        mem[0] = 16'h8001;
        mem[1] = 16'h7FFE;
        start_frame();
        run_to_done();
        for (int i = 0; i < 3; i++) cyc();
        chk("B_head32", head_bits, 32'h8001_7FFE);
        check_frame("B", 1'b1);
        mem[0] = 16'h0000 ^ 16'hA5C3;
        mem[1] = 16'h0001 ^ 16'hA5C3;

        // C: random backpressure (~40% ready)
        ready_rand = 1'b1;
        start_frame();
        run_to_done();
        for (int i = 0; i < 3; i++) cyc();
        check_frame("C", 1'b0);
        ready_rand = 1'b0;

        // D: frame_start pulsed mid-frame is ignored
        start_frame();
        start_at_pix = 5000;
        run_to_done();
        chk("D_midstart_fired", start_at_pix, -1);
        check_frame("D", 1'b1);

        // E: frame_start coincident with frame_done
        chk("E_done_at_start", frame_done, 1'b1);
        start_frame();
        run_to_done();
        for (int i = 0; i < 3; i++) cyc();
        check_frame("E", 1'b1);

        // F: reset mid-frame, then a clean frame
        start_frame();
        for (int i = 0; i < BUDGET && pix_idx < 7000; i++) cyc();
        chk("F_reached_7000", pix_idx, 7000);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("F_rst_addr", read_address, 0);
        chk("F_rst_valid", pixel_valid, 1'b0);
        chk("F_rst_busy", busy, 1'b0);
        chk("F_rst_done", frame_done, 1'b0);
        chk("F_rst_pixel", pixel, 1'b0);
        stale_bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (pixel_valid !== 1'b0 || busy !== 1'b0 || read_address !== '0) stale_bad++;
        end
        chk("F_stale_ignored", stale_bad, 0);
        start_frame();
        run_to_done();
        for (int i = 0; i < 3; i++) cyc();
        check_frame("F", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_scanout_reader.md
Name:
fb_scanout_reader

Overview:
- Read side of the 512x256 monochrome framebuffer: 8192 words x 16 bits, one bit per pixel.
- Drives the framebuffer's registered read port (read_address out, q in) and serialises each word into a 1-bit pixel stream.
- Output uses a valid/ready handshake consumed by the display timing/VGA output stage.
- Keeps one prefetched word so the stream runs at 1 pixel/cycle with no bubbles at word boundaries.

Parameters:
- ADDR_WIDTH, 13, framebuffer word-address width.
- WORD_WIDTH, 16, pixels per framebuffer word.
- FRAME_WORDS, 8192, words per frame; last address is FRAME_WORDS-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- frame_start  input  1  single-cycle request to scan one full frame from address 0.
- read_address  output  ADDR_WIDTH  framebuffer read address, registered.
- q  input  WORD_WIDTH  framebuffer read data; valid one clock after the RAM samples read_address.
- pixel  output  1  current pixel; 1 = white.
- pixel_valid  output  1  pixel holds a valid pixel.
- pixel_ready  input  1  consumer accepts pixel on this edge when pixel_valid=1.
- busy  output  1  high from accepted frame_start until frame_done.
- frame_done  output  1  one-cycle pulse after the last pixel of the frame is accepted.

Behaviour:
Reset (reset_n=0 at an edge):
- read_address=0, pixel=0, pixel_valid=0, busy=0, frame_done=0.
- Shifter, prefetch and pending-read flags all cleared; state=IDLE.
- Any in-flight RAM read is discarded. A q arriving after reset is ignored.

Read timing:
- read_address is loaded on edge E. The RAM samples it on E+1. The block captures q on edge E+2.
- A 2-stage pending pipeline tracks this.
- At most one read is outstanding; a read is issued only when the prefetch slot is empty and no read is pending.

States:
- IDLE:
  - busy=0.
  - frame_start=1 -> read_address<=0, pending set, word counter<=0, state=RUN, busy<=1.
- RUN:
  - Captured q goes to the prefetch register.
  - If the shifter is empty, or its last bit is being accepted on the same edge, the prefetch word moves into the shifter.
  - On issue, read_address increments and the counter tracks words issued. Issuing stops after FRAME_WORDS-1 has been issued.
- DRAIN (folded into RUN; no separate state required):
  - When all words are issued, none pending, prefetch empty, and the last bit is accepted: frame_done=1 for exactly one cycle, busy<=0, state=IDLE.
  - read_address holds FRAME_WORDS-1 until the next frame_start.

Pixel order:
- MSB first: bit WORD_WIDTH-1 of each word is the leftmost pixel.
- Word k holds pixels 16k..16k+15 in raster order: row = k/32, column = (k%32)*16 + bit position from the MSB.

Handshake:
- Shifter advances only on pixel_valid & pixel_ready.
- pixel and pixel_valid are held stable while pixel_valid=1 and pixel_ready=0.
- pixel_valid deasserts only when the shifter is empty with no prefetched word.

Latency:
- frame_start sampled on edge 0 -> q captured edge 2 -> shifter loaded edge 3 -> pixel_valid=1 after edge 3.

Throughput:
- With pixel_ready held 1, exactly 131072 consecutive valid pixels with no gaps.
- frame_done pulses on the edge after the 131072nd acceptance.

Boundaries:
- frame_start while busy=1: ignored, no restart, no effect on addresses.
- frame_start in the same cycle as frame_done: accepted; the new frame begins from address 0.
- Address counter never wraps within a frame. The word after 8191 is never requested.
- Stalls of any length: no words lost or duplicated. The prefetch slot holds one word; no read is issued while it is full.
- Reset mid-frame: the next frame after frame_start starts cleanly at address 0, pixel 0.

Test Plan:
- Reset with frame_start=1 and pixel_ready=1 held for 5 cycles -> read_address=0, pixel_valid=0, busy=0, frame_done=0 throughout.
- RAM model preloaded with mem[k]=k^16'hA5C3; frame_start, pixel_ready=1 -> pixel_valid rises 3 cycles after frame_start; 131072 contiguous pixels match MSB-first bits of each word; frame_done pulses once, exactly one cycle after the last acceptance.
- Word-boundary pattern mem[0]=16'h8001, mem[1]=16'h7FFE -> pixel stream 1,0x14,1,0,1x14,0; no bubble between pixel 15 and pixel 16.
- Random pixel_ready (~40% duty) over a full frame -> identical pixel sequence to the unstalled run; pixel stable while stalled; never more than one outstanding read.
- frame_start pulsed at pixel 5000 mid-frame -> ignored; stream continuous; single frame_done. Second frame_start coincident with frame_done -> new frame from address 0.
- reset_n low for 1 cycle at pixel 70000, then frame_start -> outputs at reset values; stale q ignored; new frame starts with mem[0] bit 15.
